muldiv_unit: RTL and testbench

//   Iterative multiply/divide unit beside the ALU; owns the HI/LO registers.

---
 rtl/muldiv_unit.sv | 143 ++++++++++++++
 tb/tb_muldiv_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit that owns the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, with sign fixup in a final cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [6:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [6:0] OP_DIV   = 7'd7;
  localparam logic [6:0] OP_DIVU  = 7'd8;
  localparam logic [6:0] OP_MTHI  = 7'd11;
  localparam logic [6:0] OP_MTLO  = 7'd12;
  localparam logic [6:0] OP_MULT  = 7'd13;
  localparam logic [6:0] OP_MULTU = 7'd14;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] m_reg;
  logic [CW-1:0]    cnt_reg;
  logic             div_reg, zero_reg, neg_q_reg, neg_r_reg;
  logic [WIDTH-1:0] hi_reg, lo_reg;

  logic             can_accept, accept_md, is_div, is_signed, b_zero;
  logic [WIDTH-1:0] a_abs, b_abs;

  assign can_accept = start && (state_reg == IDLE || state_reg == DONE);
  assign is_div     = (op == OP_DIV) || (op == OP_DIVU);
  assign is_signed  = (op == OP_DIV) || (op == OP_MULT);
  assign accept_md  = can_accept && (is_div || op == OP_MULT || op == OP_MULTU);
  assign b_zero     = (b == '0);
  assign a_abs      = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_abs      = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // Iteration datapath: acc holds the product upper half or the partial remainder.
  logic [WIDTH:0]   mul_sum, rem_shift, rem_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign mul_sum   = {1'b0, acc_reg} + {1'b0, (q_reg[0] ? m_reg : {WIDTH{1'b0}})};
  assign rem_shift = {acc_reg, q_reg[WIDTH-1]};
  // rem_shift < 2*divisor, so bit WIDTH of the difference is the borrow.
  assign rem_diff  = rem_shift - {1'b0, m_reg};

  assign prod     = {acc_reg, q_reg};
  assign prod_fix = neg_q_reg ? (~prod + 1'b1) : prod;
  assign quo_fix  = zero_reg ? {WIDTH{1'b1}} : (neg_q_reg ? (~q_reg + 1'b1) : q_reg);
  assign rem_fix  = (neg_r_reg && !zero_reg) ? (~acc_reg + 1'b1) : acc_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: state_next = accept_md ? CALC : IDLE;
      CALC:       state_next = (cnt_reg == CW'(WIDTH - 1)) ? FIX : CALC;
      FIX:        state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == CALC) || (state_reg == FIX);
    done = (state_reg == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg   <= '0;
      q_reg     <= '0;
      m_reg     <= '0;
      cnt_reg   <= '0;
      div_reg   <= 1'b0;
      zero_reg  <= 1'b0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      if (can_accept && op == OP_MTHI) begin
        hi_reg <= a;
      end
      if (can_accept && op == OP_MTLO) begin
        lo_reg <= a;
      end
      if (accept_md) begin
        acc_reg   <= '0;
        // A zero divisor keeps the raw dividend so the remainder comes out as the original a.
        q_reg     <= (is_div && b_zero) ? a : a_abs;
        m_reg     <= b_abs;
        cnt_reg   <= '0;
        div_reg   <= is_div;
        zero_reg  <= is_div && b_zero;
        neg_q_reg <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]) && !(is_div && b_zero);
        neg_r_reg <= is_signed && is_div && a[WIDTH-1];
      end else if (state_reg == CALC) begin
        cnt_reg <= cnt_reg + 1'b1;
        if (div_reg) begin
          if (!rem_diff[WIDTH]) begin
            acc_reg <= rem_diff[WIDTH-1:0];
            q_reg   <= {q_reg[WIDTH-2:0], 1'b1};
          end else begin
            acc_reg <= rem_shift[WIDTH-1:0];
            q_reg   <= {q_reg[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_reg <= mul_sum[WIDTH:1];
          q_reg   <= {mul_sum[0], q_reg[WIDTH-1:1]};
        end
      end else if (state_reg == FIX) begin
        if (div_reg) begin
          hi_reg <= rem_fix;
          lo_reg <= quo_fix;
        end else begin
          hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
          lo_reg <= prod_fix[WIDTH-1:0];
        end
      end
    end
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: arithmetic reference model, queued expectations,
// and a monitor that checks every done pulse for value and latency.
module tb_muldiv_unit;

  localparam logic [6:0] OP_DIV   = 7'd7;
  localparam logic [6:0] OP_DIVU  = 7'd8;
  localparam logic [6:0] OP_MTHI  = 7'd11;
  localparam logic [6:0] OP_MTLO  = 7'd12;
  localparam logic [6:0] OP_MULT  = 7'd13;
  localparam logic [6:0] OP_MULTU = 7'd14;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
    int          opn;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference results {hi, lo} straight from the arithmetic definition.
  function automatic logic [63:0] ref_model(input logic [6:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sp;
    longint unsigned up;
    int              sx, sy;
    sx = x;
    sy = y;
    case (o)
      OP_MULT: begin
        sp = longint'(sx) * longint'(sy);
        return sp;
      end
      OP_MULTU: begin
        up = {32'd0, x} * {32'd0, y};
        return up;
      end
      OP_DIV: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        return {32'(sx % sy), 32'(sx / sy)};
      end
      OP_DIVU: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest expectation, on its due cycle.
  always @(negedge clk) begin
    if (reset_n && done) begin
      check("busy_with_done", {31'd0, busy}, 32'd0);
      if (sb.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_done: got done with empty scoreboard, want none");
      end else begin
        e = sb.pop_front();
        check($sformatf("hi op%0d", e.opn), hi, e.hi);
        check($sformatf("lo op%0d", e.opn), lo, e.lo);
        check($sformatf("latency op%0d", e.opn), cyc, e.due);
        $display("result op=%0d hi=%h lo=%h cycle=%0d", e.opn, hi, lo, cyc);
      end
    end
  end

  // Drive one request for a single edge; call before a rising edge (normally at a falling edge).
  task automatic issue(input logic [6:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r;
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (o == OP_MULT || o == OP_MULTU || o == OP_DIV || o == OP_DIVU) begin
      r = ref_model(o, x, y);
      // Accept edge is edge k; done is visible after edge k+33.
      sb.push_back('{r[63:32], r[31:0], cyc + 33, int'(o)});
    end
  endtask

  task automatic wait_done(output int nbusy);
    bit seen;
    seen = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      nvec++;
      nerr++;
      $display("FAIL done_timeout: got no done in 60 cycles, want done");
    end
  endtask

  task automatic mt(input logic [6:0] o, input logic [31:0] x);
    issue(o, x, 32'd0);
    if (o == OP_MTHI) check("mthi_hi", hi, x);
    else              check("mtlo_lo", lo, x);
    check("mt_busy", {31'd0, busy}, 32'd0);
    check("mt_done", {31'd0, done}, 32'd0);
  endtask

  typedef struct {
    logic [6:0]  o;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] eh;
    logic [31:0] el;
  } dir_t;

  dir_t dir[8];
  int nb;
  logic [31:0] hold_hi, hold_lo;

  initial begin
    dir[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    dir[1] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    dir[2] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    dir[3] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    dir[4] = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    dir[5] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    dir[6] = '{OP_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
    dir[7] = '{OP_DIV,   32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF};

    repeat (3) @(posedge clk);
    #1;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed cases, each issued in the DONE cycle of the previous one.
    for (int i = 0; i < 8; i++) begin
      issue(dir[i].o, dir[i].x, dir[i].y);
      wait_done(nb);
      check($sformatf("dir%0d_busy_cycles", i), nb, 32'd33);
      check($sformatf("dir%0d_hi", i), hi, dir[i].eh);
      check($sformatf("dir%0d_lo", i), lo, dir[i].el);
      $display("directed %0d op=%0d a=%h b=%h hi=%h lo=%h", i, dir[i].o, dir[i].x, dir[i].y, hi, lo);
    end

    // Back-to-back MT writes on consecutive edges.
    @(negedge clk);
    op = OP_MTHI;
    a = 32'hA5A5A5A5;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("mthi_seq_hi", hi, 32'hA5A5A5A5);
    check("mthi_seq_busy", {31'd0, busy}, 32'd0);
    op = OP_MTLO;
    a = 32'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("mtlo_seq_lo", lo, 32'd1);
    check("mtlo_seq_hi", hi, 32'hA5A5A5A5);
    check("mtlo_seq_done", {31'd0, done}, 32'd0);
    $display("mt sequence hi=%h lo=%h", hi, lo);

    // MTLO while busy is dropped.
    @(negedge clk);
    issue(OP_MULTU, 32'd3, 32'd4);
    repeat (3) @(negedge clk);
    hold_lo = lo;
    op = OP_MTLO;
    a = 32'hDEADBEEF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ignored_mtlo_lo", lo, hold_lo);
    check("ignored_mtlo_busy", {31'd0, busy}, 32'd1);
    wait_done(nb);
    check("after_ignored_lo", lo, 32'd12);

    // Unknown opcode has no effect.
    @(negedge clk);
    hold_hi = hi;
    hold_lo = lo;
    issue(7'd3, 32'h11111111, 32'h22222222);
    check("unknown_hi", hi, hold_hi);
    check("unknown_lo", lo, hold_lo);
    check("unknown_busy", {31'd0, busy}, 32'd0);
    $display("unknown op hi=%h lo=%h", hi, lo);

    // Randomized mix; each request issued as soon as the previous result lands.
    for (int i = 0; i < 40; i++) begin
      logic [6:0]  o;
      logic [31:0] x, y;
      int sel;
      sel = $urandom_range(0, 5);
      o = (sel == 0) ? OP_MULT : (sel == 1) ? OP_MULTU : (sel == 2) ? OP_DIV :
          (sel == 3) ? OP_DIVU : (sel == 4) ? OP_MTHI : OP_MTLO;
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = 32'd0;
        1: y = $urandom_range(1, 16);
        2: y = -$urandom_range(1, 16);
        default: y = $urandom;
      endcase
      if (o == OP_MTHI || o == OP_MTLO) begin
        mt(o, x);
        $display("random %0d op=%0d a=%h hi=%h lo=%h", i, o, x, hi, lo);
        @(negedge clk);
      end else begin
        issue(o, x, y);
        wait_done(nb);
        $display("random %0d op=%0d a=%h b=%h hi=%h lo=%h", i, o, x, y, hi, lo);
      end
    end

    // Reset in the middle of an operation.
    @(negedge clk);
    mt(OP_MTHI, 32'hCAFEF00D);
    @(negedge clk);
    issue(OP_MULTU, 32'h12345678, 32'h9ABCDEF0);
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    sb.delete();
    check("midreset_hi", hi, 32'd0);
    check("midreset_lo", lo, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    $display("mid-op reset hi=%h lo=%h busy=%b", hi, lo, busy);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(nb);
    check("post_reset_lo", lo, 32'd14);
    check("post_reset_hi", hi, 32'd2);
    check("post_reset_busy_cycles", nb, 32'd33);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by 1000000, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
